// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file and its busy scoreboard.
// The optional write-to-read forwarding path is selected with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int ADDRESS_LEN_DEF = 5;
    localparam int N_DEF           = 32;
    localparam int REG_ZERO        = 0;

    // Port 0 carries ALU results, port 1 the load / long-latency path.
    localparam int NUM_WR  = 2;
    localparam int WR_ALU  = 0;
    localparam int WR_LOAD = 1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue claims a destination, writeback releases it.
// A same-cycle claim beats a release because the newly issued producer owns the register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_LEN = ADDRESS_LEN_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_WR-1:0]             wr_en_i,
    input  logic [NUM_WR*ADDRESS_LEN-1:0] wr_addr_i,
    input  logic                          claim_en_i,
    input  logic [ADDRESS_LEN-1:0]        claim_addr_i,
    output logic [2**ADDRESS_LEN-1:0]     busy_o,
    output logic                          any_busy_o
);

    localparam int DEPTH = 2**ADDRESS_LEN;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en_i[p]) begin
                busy_d[wr_addr_i[p*ADDRESS_LEN +: ADDRESS_LEN]] = 1'b0;
            end
        end
        if (claim_en_i) begin
            busy_d[claim_addr_i] = 1'b1;
        end
        // x0 can never have an outstanding producer.
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign any_busy_o = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD combinational read ports, two write ports, x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy status to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDRESS_LEN = ADDRESS_LEN_DEF,
    parameter int N           = N_DEF,
    parameter int NUM_RD      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RD*ADDRESS_LEN-1:0] rd_addr,
    output logic [NUM_RD*N-1:0]           rd_data,
    output logic [NUM_RD-1:0]             rd_busy,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*ADDRESS_LEN-1:0] wr_addr,
    input  logic [NUM_WR*N-1:0]           wr_data,
    input  logic                          claim_en,
    input  logic [ADDRESS_LEN-1:0]        claim_addr,
    output logic                          any_busy
);

    localparam int DEPTH = 2**ADDRESS_LEN;

    logic [N-1:0]     regs_q [DEPTH];
    logic [N-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0] busy;

    regfile_scoreboard #(
        .ADDRESS_LEN (ADDRESS_LEN)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .claim_en_i   (claim_en),
        .claim_addr_i (claim_addr),
        .busy_o       (busy),
        .any_busy_o   (any_busy)
    );

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_addr[p*ADDRESS_LEN +: ADDRESS_LEN] != ADDRESS_LEN'(REG_ZERO))) begin
                regs_d[wr_addr[p*ADDRESS_LEN +: ADDRESS_LEN]] = wr_data[p*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (rd_addr[k*ADDRESS_LEN +: ADDRESS_LEN] != ADDRESS_LEN'(REG_ZERO)) begin
                rd_data[k*N +: N] = regs_q[rd_addr[k*ADDRESS_LEN +: ADDRESS_LEN]];
                rd_busy[k]        = busy[rd_addr[k*ADDRESS_LEN +: ADDRESS_LEN]];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && (wr_addr[p*ADDRESS_LEN +: ADDRESS_LEN] ==
                                     rd_addr[k*ADDRESS_LEN +: ADDRESS_LEN])) begin
                        rd_data[k*N +: N] = wr_data[p*N +: N];
                        rd_busy[k]        = claim_en &&
                                            (claim_addr == rd_addr[k*ADDRESS_LEN +: ADDRESS_LEN]);
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_mp;

    localparam int AL = 5;
    localparam int N  = 32;
    localparam int NR = 2;

    logic            clk;
    logic            rst;
    logic [NR*AL-1:0] rd_addr;
    logic [NR*N-1:0]  rd_data;
    logic [NR-1:0]    rd_busy;
    logic [1:0]       wr_en;
    logic [2*AL-1:0]  wr_addr;
    logic [2*N-1:0]   wr_data;
    logic             claim_en;
    logic [AL-1:0]    claim_addr;
    logic             any_busy;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.ADDRESS_LEN(AL), .N(N), .NUM_RD(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .any_busy   (any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge so they settle well before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 2'b00;
        claim_en = 1'b0;
    endtask

    task automatic setRead(input logic [AL-1:0] a0, input logic [AL-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic applyWrite(input int p, input logic [AL-1:0] a, input logic [N-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AL +: AL] = a;
        wr_data[p*N +: N]   = d;
    endtask

    task automatic test_reset();
        applyWrite(0, 5'd5, 32'hDEADBEEF);
        claim_en = 1'b1; claim_addr = 5'd7;
        tick(); idle();
        setRead(5'd5, 5'd7);
        checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL preload_r5: got %h expected deadbeef", rd_data[31:0]); end
        checks++; if (rd_busy !== 2'b10) begin errors++; $display("[TB] FAIL preload_busy: got %b expected 10", rd_busy); end
        rst = 1'b1;
        applyWrite(1, 5'd8, 32'h0BAD0BAD);
        tick(); idle(); rst = 1'b0;
        setRead(5'd5, 5'd7);
        checks++; if (rd_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", rd_data); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 00", rd_busy); end
        checks++; if (any_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_any_busy: got %b expected 0", any_busy); end
        setRead(5'd8, 5'd8);
        checks++; if (rd_data[63:32] !== 32'h0) begin errors++; $display("[TB] FAIL reset_write_lost: got %h expected 0", rd_data[63:32]); end
    endtask

    task automatic test_write_read();
        applyWrite(0, 5'd3, 32'h12345678);
        tick(); idle();
        setRead(5'd3, 5'd0);
        checks++; if (rd_data[31:0] !== 32'h12345678) begin errors++; $display("[TB] FAIL rd_r3: got %h expected 12345678", rd_data[31:0]); end
        applyWrite(0, 5'd0, 32'hFFFFFFFF);
        applyWrite(1, 5'd0, 32'hFFFFFFFF);
        tick(); idle();
        setRead(5'd0, 5'd3);
        checks++; if (rd_data !== {32'h12345678, 32'h0}) begin errors++; $display("[TB] FAIL rd_r0: got %h expected 12345678_00000000", rd_data); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("[TB] FAIL busy_r0: got %b expected 00", rd_busy); end
    endtask

    task automatic test_collision();
        applyWrite(0, 5'd9, 32'h1111);
        applyWrite(1, 5'd9, 32'h2222);
        tick(); idle();
        setRead(5'd9, 5'd9);
        checks++; if (rd_data !== {32'h2222, 32'h2222}) begin errors++; $display("[TB] FAIL collision_r9: got %h expected 2222 on both", rd_data); end
        applyWrite(0, 5'd10, 32'hA0A0);
        applyWrite(1, 5'd11, 32'hB1B1);
        tick(); idle();
        setRead(5'd10, 5'd11);
        checks++; if (rd_data !== {32'hB1B1, 32'hA0A0}) begin errors++; $display("[TB] FAIL dual_write: got %h expected b1b1_a0a0", rd_data); end
    endtask

    task automatic test_scoreboard();
        claim_en = 1'b1; claim_addr = 5'd4;
        tick(); idle();
        setRead(5'd4, 5'd3);
        checks++; if (rd_busy !== 2'b01) begin errors++; $display("[TB] FAIL claim_busy: got %b expected 01", rd_busy); end
        checks++; if (any_busy !== 1'b1) begin errors++; $display("[TB] FAIL claim_any: got %b expected 1", any_busy); end
        applyWrite(1, 5'd4, 32'hAB);
        tick(); idle();
        setRead(5'd4, 5'd3);
        checks++; if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'hAB) begin errors++; $display("[TB] FAIL release: got busy=%b data=%h expected busy=00 data=ab", rd_busy, rd_data[31:0]); end
        checks++; if (any_busy !== 1'b0) begin errors++; $display("[TB] FAIL release_any: got %b expected 0", any_busy); end
        claim_en = 1'b1; claim_addr = 5'd4;
        applyWrite(0, 5'd4, 32'hCD);
        tick(); idle();
        setRead(5'd4, 5'd0);
        checks++; if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'hCD) begin errors++; $display("[TB] FAIL claim_wins: got busy=%b data=%h expected busy=1 data=cd", rd_busy[0], rd_data[31:0]); end
        claim_en = 1'b1; claim_addr = 5'd4;
        tick(); idle();
        applyWrite(0, 5'd4, 32'hCE);
        tick(); idle();
        setRead(5'd4, 5'd0);
        checks++; if (rd_busy[0] !== 1'b0 || any_busy !== 1'b0) begin errors++; $display("[TB] FAIL reclaim_release: got busy=%b any=%b expected 0 0", rd_busy[0], any_busy); end
        applyWrite(1, 5'd12, 32'h77);
        tick(); idle();
        setRead(5'd12, 5'd0);
        checks++; if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h77) begin errors++; $display("[TB] FAIL nonbusy_write: got busy=%b data=%h expected busy=0 data=77", rd_busy[0], rd_data[31:0]); end
    endtask

    task automatic test_bypass();
        applyWrite(0, 5'd6, 32'h1);
        tick(); idle();
        applyWrite(0, 5'd6, 32'h55AA);
        setRead(5'd6, 5'd3);
`ifdef REGFILE_BYPASS_EN
        checks++; if (rd_data[31:0] !== 32'h55AA || rd_busy[0] !== 1'b0) begin errors++; $display("[TB] FAIL bypass_same: got data=%h busy=%b expected 55aa 0", rd_data[31:0], rd_busy[0]); end
        claim_en = 1'b1; claim_addr = 5'd6;
        #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL bypass_claim: got %b expected 1", rd_busy[0]); end
`else
        checks++; if (rd_data[31:0] !== 32'h1 || rd_busy[0] !== 1'b0) begin errors++; $display("[TB] FAIL nobypass_same: got data=%h busy=%b expected 1 0", rd_data[31:0], rd_busy[0]); end
`endif
        tick(); idle();
        setRead(5'd6, 5'd3);
        checks++; if (rd_data[31:0] !== 32'h55AA) begin errors++; $display("[TB] FAIL bypass_next: got %h expected 55aa", rd_data[31:0]); end
        applyWrite(0, 5'd6, 32'h0);
        tick(); idle();
    endtask

    task automatic test_claim_zero();
        claim_en = 1'b1; claim_addr = 5'd0;
        setRead(5'd0, 5'd0);
        tick(); idle();
        setRead(5'd0, 5'd0);
        checks++; if (rd_busy !== 2'b00 || rd_data !== 64'h0 || any_busy !== 1'b0) begin errors++; $display("[TB] FAIL claim_r0: got busy=%b data=%h any=%b expected 00 0 0", rd_busy, rd_data, any_busy); end
        claim_en = 1'b1; claim_addr = 5'd13;
        tick();
        claim_addr = 5'd0;
        tick(); idle();
        setRead(5'd0, 5'd13);
        checks++; if (rd_busy !== 2'b10 || any_busy !== 1'b1) begin errors++; $display("[TB] FAIL claim_r0_any: got busy=%b any=%b expected 10 1", rd_busy, any_busy); end
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        claim_en = 1'b0; claim_addr = '0;
        tick();
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_collision();
        test_scoreboard();
        test_bypass();
        test_claim_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
